// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: store encodings,
// MMIO register map, STATUS bit layout and small decode helpers.
package data_mem_ctrl_pkg;

    // One-hot store encodings on data_mem_we; all-zero means read.
    localparam logic [2:0] WE_RD = 3'b000;
    localparam logic [2:0] WE_SB = 3'b001;
    localparam logic [2:0] WE_SH = 3'b010;
    localparam logic [2:0] WE_SW = 3'b100;

    localparam logic [31:0] MMIO_BASE_DEF = 32'h8000_0000;

    // MMIO register select taken from addr[3:2].
    typedef enum logic [1:0] {
        MMIO_TXDATA = 2'd0,
        MMIO_STATUS = 2'd1,
        MMIO_CYCLE  = 2'd2,
        MMIO_RSVD   = 2'd3
    } mmio_sel_e;

    // STATUS register bit positions.
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;

    // Byte-lane enables for a RAM store; misaligned or non-one-hot stores give none.
    function automatic logic [3:0] lane_enable(input logic [2:0] we, input logic [1:0] off);
        logic [3:0] en;
        case (we)
            WE_SB:   en = 4'b0001 << off;
            WE_SH:   en = off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
            WE_SW:   en = (off == 2'd0) ? 4'b1111 : 4'b0000;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    // Packs the STATUS read value.
    function automatic logic [31:0] status_word(input logic [3:0] cnt, input logic ovf,
                                                input logic empty, input logic full);
        return {25'd0, cnt, ovf, empty, full};
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core data-memory port plus the TX byte stream, bundled for the controller.
interface data_mem_ctrl_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] data_mem_addr;
    logic [XLEN-1:0] data_mem_wdata;
    logic [2:0]      data_mem_we;
    logic [XLEN-1:0] data_mem_out;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;

    // Core / consumer side.
    modport master (
        output data_mem_addr, data_mem_wdata, data_mem_we, tx_ready,
        input  data_mem_out, tx_data, tx_valid
    );

    // Controller side.
    modport slave (
        input  data_mem_addr, data_mem_wdata, data_mem_we, tx_ready,
        output data_mem_out, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem_ctrl_sync_fifo.sv
// Small synchronous FIFO with registered occupancy count. Pushes while full
// and pops while empty are ignored; the caller tracks overflow.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage, pointers and count; reset flushes everything so the head reads 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));
    assign o_count = r_count;
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller behind the core's data port: byte-lane RAM,
// memory-mapped TX FIFO with sticky overflow, and a free-running cycle counter.
// Reads are registered and refreshed every cycle from the current address.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          RAM_AWIDTH = 12,
    parameter int          TX_DEPTH   = 8,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_ctrl_if.slave bus
);
    localparam int WORDS = 2 ** (RAM_AWIDTH - 2);
    localparam int CW    = $clog2(TX_DEPTH + 1);

    logic [3:0][7:0]         r_ram [WORDS];
    logic [XLEN-1:0]         r_out;
    logic                    r_we_q;
    logic                    r_ovf;
    logic [31:0]             r_cycle;

    logic                    w_we_edge;
    logic                    w_one_hot;
    logic                    w_is_mmio;
    mmio_sel_e               w_sel;
    logic [RAM_AWIDTH-3:0]   w_idx;
    logic [3:0]              w_lane_en;
    logic [31:0]             w_wdata_lanes;
    logic [XLEN-1:0]         w_rd_word;
    logic                    w_tx_store;
    logic                    w_st_clear;
    logic                    w_push;
    logic                    w_pop;
    logic [7:0]              w_fifo_data;
    logic                    w_full;
    logic                    w_empty;
    logic [CW-1:0]           w_count;
    logic                    w_unused_addr_bits;

    assign w_we_edge = (|bus.data_mem_we) && !r_we_q;
    assign w_one_hot = (bus.data_mem_we == WE_SB) || (bus.data_mem_we == WE_SH) ||
                       (bus.data_mem_we == WE_SW);
    assign w_is_mmio = (bus.data_mem_addr[XLEN-1] == MMIO_BASE[31]);
    assign w_sel     = mmio_sel_e'(bus.data_mem_addr[3:2]);
    assign w_idx     = bus.data_mem_addr[RAM_AWIDTH-1:2];
    assign w_lane_en = w_is_mmio ? 4'b0000 : lane_enable(bus.data_mem_we, bus.data_mem_addr[1:0]);
    assign w_unused_addr_bits = ^bus.data_mem_addr[XLEN-2:RAM_AWIDTH];

    // Replicate store data so every lane sees its byte regardless of offset.
    always_comb begin
        w_wdata_lanes = bus.data_mem_wdata;
        case (bus.data_mem_we)
            WE_SB:   w_wdata_lanes = {4{bus.data_mem_wdata[7:0]}};
            WE_SH:   w_wdata_lanes = {2{bus.data_mem_wdata[15:0]}};
            WE_SW:   w_wdata_lanes = bus.data_mem_wdata;
            default: w_wdata_lanes = bus.data_mem_wdata;
        endcase
    end

    // RAM byte-lane writes; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (w_lane_en[l]) begin
                r_ram[w_idx][l] <= w_wdata_lanes[l*8 +: 8];
            end
        end
    end

    // Side-effecting MMIO stores fire once per held store (rising edge of we).
    assign w_tx_store = w_we_edge && w_one_hot && w_is_mmio && (w_sel == MMIO_TXDATA);
    assign w_st_clear = w_we_edge && w_one_hot && w_is_mmio && (w_sel == MMIO_STATUS) &&
                        bus.data_mem_wdata[ST_OVF];
    assign w_push     = w_tx_store && !w_full;
    assign w_pop      = !w_empty && bus.tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.data_mem_wdata[7:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Select the unshifted read word from RAM or the MMIO register file.
    always_comb begin
        w_rd_word = {XLEN{1'b0}};
        if (w_is_mmio) begin
            case (w_sel)
                MMIO_STATUS: w_rd_word = status_word(4'(w_count), r_ovf, w_empty, w_full);
                MMIO_CYCLE:  w_rd_word = r_cycle;
                default:     w_rd_word = {XLEN{1'b0}};
            endcase
        end else begin
            w_rd_word = r_ram[w_idx];
        end
    end

    // Registered read data, store edge history, overflow flag and cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= {XLEN{1'b0}};
            r_we_q  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cycle <= 32'd0;
        end else begin
            r_out   <= w_rd_word >> {bus.data_mem_addr[1:0], 3'b000};
            r_we_q  <= |bus.data_mem_we;
            r_cycle <= r_cycle + 32'd1;
            if (w_tx_store && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_st_clear) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    assign bus.data_mem_out = r_out;
    assign bus.tx_data      = w_fifo_data;
    assign bus.tx_valid     = !w_empty;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a vector table for RAM/MMIO reads and stores,
// then hand-written sequences for FIFO edge detect, overflow, push+pop and reset.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc_model = 0;

    logic [31:0] sb_q [$];
    logic [7:0]  tx_model [$];

    data_mem_ctrl_if #(.XLEN(32)) bus();

    data_mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  we;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    localparam logic [31:0] A_TX  = 32'h8000_0000;
    localparam logic [31:0] A_ST  = 32'h8000_0004;
    localparam logic [31:0] A_CYC = 32'h8000_0008;
    localparam logic [31:0] A_RSV = 32'h8000_000C;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, check head byte if consumer is ready, compare read after the edge.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] we, input logic rdy, input logic chk,
                        input logic [31:0] exp, input string nm);
        logic [31:0] e;
        rst                = r;
        bus.data_mem_addr  = a;
        bus.data_mem_wdata = wd;
        bus.data_mem_we    = we;
        bus.tx_ready       = rdy;
        if (chk) sb_q.push_back(exp);
        if (rdy && !r && tx_model.size() > 0) begin
            check({nm, "_txvalid"}, {31'd0, bus.tx_valid}, 32'd1);
            check({nm, "_txdata"}, {24'd0, bus.tx_data}, {24'd0, tx_model.pop_front()});
        end
        @(posedge clk);
        #1;
        cyc_model = r ? 0 : cyc_model + 1;
        if (chk) begin
            e = sb_q.pop_front();
            check(nm, bus.data_mem_out, e);
        end
    endtask

    initial begin
        logic [31:0] st_exp;
        int cnt;

        vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 3'b100, 1'b0, 32'h0};
        vecs[1]  = '{32'h0000_0010, 32'h0,         3'b000, 1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{32'h0000_0013, 32'h0000_00A5, 3'b001, 1'b1, 32'h0000_00DE};
        vecs[3]  = '{32'h0000_0010, 32'h0,         3'b000, 1'b1, 32'hA5AD_BEEF};
        vecs[4]  = '{32'h0000_0013, 32'h0,         3'b000, 1'b1, 32'h0000_00A5};
        vecs[5]  = '{32'h0000_0011, 32'h0000_1234, 3'b010, 1'b1, 32'h00A5_ADBE};
        vecs[6]  = '{32'h0000_0010, 32'h0,         3'b000, 1'b1, 32'hA5AD_BEEF};
        vecs[7]  = '{32'h0000_0012, 32'h0000_1234, 3'b010, 1'b1, 32'h0000_A5AD};
        vecs[8]  = '{32'h0000_0010, 32'h0,         3'b000, 1'b1, 32'h1234_BEEF};
        vecs[9]  = '{32'h0000_0010, 32'h0,         3'b011, 1'b1, 32'h1234_BEEF};
        vecs[10] = '{32'h0000_0010, 32'h0,         3'b000, 1'b1, 32'h1234_BEEF};
        vecs[11] = '{32'h0000_1010, 32'h0,         3'b000, 1'b1, 32'h1234_BEEF};
        vecs[12] = '{32'h0000_0012, 32'hFFFF_FFFF, 3'b100, 1'b1, 32'h0000_1234};
        vecs[13] = '{32'h0000_0010, 32'h0,         3'b000, 1'b1, 32'h1234_BEEF};
        vecs[14] = '{32'h0000_0010, 32'hFFFF_FF77, 3'b001, 1'b1, 32'h1234_BEEF};
        vecs[15] = '{32'h0000_0010, 32'h0,         3'b000, 1'b1, 32'h1234_BE77};
        vecs[16] = '{A_RSV,         32'hFFFF_FFFF, 3'b000, 1'b1, 32'h0};

        // Reset state
        step(1'b1, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0, "rst");
        step(1'b1, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0, "rst");
        check("rst_out", bus.data_mem_out, 32'h0);
        check("rst_txvalid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_txdata", {24'd0, bus.tx_data}, 32'd0);
        step(1'b0, A_ST, 32'h0, 3'b000, 1'b0, 1'b1, 32'h0000_0002, "rst_status");

        // RAM stores, lane reads, misaligned/non-one-hot drops, aliasing
        for (int i = 0; i < 17; i++) begin
            step(1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].we, 1'b0, vecs[i].chk,
                 vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Held TXDATA store pushes exactly once
        for (int i = 0; i < 3; i++) begin
            step(1'b0, A_TX, 32'h0000_0041, 3'b100, 1'b0, 1'b1, 32'h0, "txhold_rd");
        end
        tx_model.push_back(8'h41);
        step(1'b0, A_ST, 32'h0, 3'b000, 1'b0, 1'b1, 32'h0000_0008, "txhold_status");
        check("txhold_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("txhold_data", {24'd0, bus.tx_data}, 32'h41);

        // Fill to full, one dropped push sets overflow
        cnt = 1;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, A_TX, 32'h50 + k, 3'b100, 1'b0, 1'b1, 32'h0, "fill_rd");
            if (cnt < 8) begin
                tx_model.push_back(8'(8'h50 + k));
                cnt++;
                st_exp = {25'd0, 4'(cnt), 1'b0, 1'b0, (cnt == 8)};
            end else begin
                st_exp = 32'h0000_0045;
            end
            step(1'b0, A_ST, 32'h0, 3'b000, 1'b0, 1'b1, st_exp, $sformatf("fill_status%0d", k));
        end
        step(1'b0, A_ST, 32'h0000_0004, 3'b100, 1'b0, 1'b1, 32'h0000_0045, "w1c_pre");
        step(1'b0, A_ST, 32'h0, 3'b000, 1'b0, 1'b1, 32'h0000_0041, "w1c_post");
        check("full_head", {24'd0, bus.tx_data}, 32'h41);

        // Drain to two entries, then push and pop together
        for (int i = 0; i < 6; i++) begin
            step(1'b0, A_ST, 32'h0, 3'b000, 1'b1, 1'b0, 32'h0, "drain");
        end
        step(1'b0, A_TX, 32'h0000_0060, 3'b100, 1'b1, 1'b0, 32'h0, "pushpop");
        tx_model.push_back(8'h60);
        step(1'b0, A_ST, 32'h0, 3'b000, 1'b0, 1'b1, 32'h0000_0010, "pushpop_status");
        step(1'b0, A_ST, 32'h0, 3'b000, 1'b1, 1'b1, 32'h0000_0010, "pop_a");
        step(1'b0, A_ST, 32'h0, 3'b000, 1'b1, 1'b1, 32'h0000_0008, "pop_b");
        step(1'b0, A_ST, 32'h0, 3'b000, 1'b0, 1'b1, 32'h0000_0002, "drained_status");
        check("drained_valid", {31'd0, bus.tx_valid}, 32'd0);

        // Reset in mid-operation with three bytes queued at cycle 100
        for (int k = 0; k < 3; k++) begin
            step(1'b0, A_TX, 32'h70 + k, 3'b001, 1'b0, 1'b0, 32'h0, "pre_rst_push");
            step(1'b0, A_ST, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0, "pre_rst_idle");
        end
        step(1'b0, A_ST, 32'h0, 3'b000, 1'b0, 1'b1, 32'h0000_0018, "pre_rst_status");
        for (int i = 0; i < 200 && cyc_model < 100; i++) begin
            step(1'b0, A_ST, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0, "wait");
        end
        step(1'b0, A_CYC, 32'h0, 3'b000, 1'b0, 1'b1, 32'd100, "cycle_100");
        step(1'b1, A_CYC, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0, "rst_pulse");
        tx_model.delete();
        check("rst2_txvalid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst2_txdata", {24'd0, bus.tx_data}, 32'd0);
        check("rst2_out", bus.data_mem_out, 32'h0);
        step(1'b0, A_CYC, 32'h0, 3'b000, 1'b0, 1'b1, 32'd0, "rst2_cycle0");
        step(1'b0, A_CYC, 32'h0, 3'b000, 1'b0, 1'b1, 32'd1, "rst2_cycle1");
        step(1'b0, A_ST, 32'h0, 3'b000, 1'b0, 1'b1, 32'h0000_0002, "rst2_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
